// File: rtl/mmcm_sup_pkg.sv
// Shared types and helpers for the MMCM0 lock supervisor.
package mmcm_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RST_PULSE = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } sup_state_e;

  // Width needed to hold values 0..limit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Asynchronous-reset flop chain that brings mmcm_locked into the reference clock domain.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mmcm0_lock_supervisor.sv
// MMCM0 reset/lock supervisor: pulses MMCM RST, qualifies LOCKED, gates the system reset.
// Optional retry limit with a FAIL state is enabled by defining MMCM_SUP_RETRY_LIMIT_EN.
module mmcm0_lock_supervisor
  import mmcm_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8,
  parameter int MAX_RETRIES   = 4
) (
  input  logic               clk_in0,
  input  logic               reset_n,
  input  logic               soft_rst,
  input  logic               mmcm_locked,
  input  logic               clr_status,
  output logic               mmcm_reset,
  output logic               sys_rst_n,
  output logic               lock_lost,
  output logic [CNT_W-1:0]   relock_cnt,
  output logic [STATE_W-1:0] state,
  output logic               fail
);

  localparam int RST_W    = cnt_width(RST_CYCLES);
  localparam int WAIT_W   = cnt_width(LOCK_TIMEOUT);
  localparam int STABLE_W = cnt_width(STABLE_CYCLES);

  localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(RST_CYCLES - 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);

  sup_state_e          state_q;
  logic [RST_W-1:0]    rst_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STABLE_W-1:0] stable_cnt;
  logic                locked_s;
  logic                lock_drop;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk_in0),
    .rst_n(reset_n),
    .d    (mmcm_locked),
    .q    (locked_s)
  );

`ifdef MMCM_SUP_RETRY_LIMIT_EN
  localparam int RETRY_W = cnt_width(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  logic [RETRY_W-1:0] retry_cnt;
`else
  // Without the retry limit the supervisor retries forever and never flags failure.
  assign fail = 1'b0 & (MAX_RETRIES > 0);
`endif

  always_ff @(posedge clk_in0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_PULSE;
      mmcm_reset <= 1'b1;
      sys_rst_n  <= 1'b0;
      rst_cnt    <= '0;
      wait_cnt   <= '0;
      stable_cnt <= '0;
`ifdef MMCM_SUP_RETRY_LIMIT_EN
      retry_cnt  <= '0;
      fail       <= 1'b0;
`endif
    end else if (soft_rst) begin
      state_q    <= RST_PULSE;
      mmcm_reset <= 1'b1;
      sys_rst_n  <= 1'b0;
      rst_cnt    <= '0;
`ifdef MMCM_SUP_RETRY_LIMIT_EN
      retry_cnt  <= '0;
      fail       <= 1'b0;
`endif
    end else begin
      case (state_q)
        RST_PULSE: begin
          if (rst_cnt == RST_LAST) begin
            state_q    <= WAIT_LOCK;
            mmcm_reset <= 1'b0;
            wait_cnt   <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_q    <= STABLE;
            stable_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            mmcm_reset <= 1'b1;
            rst_cnt    <= '0;
`ifdef MMCM_SUP_RETRY_LIMIT_EN
            retry_cnt  <= retry_cnt + 1'b1;
            if (retry_cnt == RETRY_LAST) begin
              state_q <= FAIL;
              fail    <= 1'b1;
            end else begin
              state_q <= RST_PULSE;
            end
`else
            state_q    <= RST_PULSE;
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        STABLE: begin
          // Any drop restarts the lock wait; only an unbroken run releases the system.
          if (!locked_s) begin
            state_q  <= WAIT_LOCK;
            wait_cnt <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state_q   <= RUN;
            sys_rst_n <= 1'b1;
`ifdef MMCM_SUP_RETRY_LIMIT_EN
            retry_cnt <= '0;
`endif
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q    <= RST_PULSE;
            mmcm_reset <= 1'b1;
            sys_rst_n  <= 1'b0;
            rst_cnt    <= '0;
          end
        end
`ifdef MMCM_SUP_RETRY_LIMIT_EN
        FAIL: begin
          state_q <= FAIL;
        end
`endif
        default: begin
          state_q    <= RST_PULSE;
          mmcm_reset <= 1'b1;
          sys_rst_n  <= 1'b0;
          rst_cnt    <= '0;
        end
      endcase
    end
  end

  // soft_rst pre-empts a simultaneous lock drop, so that drop is not recorded.
  assign lock_drop = (state_q == RUN) && !locked_s && !soft_rst;

  always_ff @(posedge clk_in0 or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost  <= 1'b0;
      relock_cnt <= '0;
    end else if (lock_drop) begin
      lock_lost <= 1'b1;
      if (clr_status) begin
        relock_cnt <= CNT_W'(1);
      end else if (relock_cnt != '1) begin
        relock_cnt <= relock_cnt + 1'b1;
      end
    end else if (clr_status) begin
      lock_lost  <= 1'b0;
      relock_cnt <= '0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mmcm0_lock_supervisor.sv
// Self-checking bench for mmcm0_lock_supervisor: directed scenarios plus random lock traffic
// against a phase/age reference model. Honors MMCM_SUP_RETRY_LIMIT_EN when defined.
module tb_mmcm0_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 50;
  localparam int STABLE_CYCLES = 8;
  localparam int SYNC_STAGES   = 2;
  localparam int CNT_W         = 2;
  localparam int MAX_RETRIES   = 3;
  localparam int CNT_MAX       = (1 << CNT_W) - 1;
`ifdef MMCM_SUP_RETRY_LIMIT_EN
  localparam bit RETRY_LIMITED = 1'b1;
`else
  localparam bit RETRY_LIMITED = 1'b0;
`endif

  logic             clk_in0 = 1'b0;
  logic             reset_n;
  logic             soft_rst;
  logic             mmcm_locked;
  logic             clr_status;
  logic             mmcm_reset;
  logic             sys_rst_n;
  logic             lock_lost;
  logic [CNT_W-1:0] relock_cnt;
  logic [2:0]       state;
  logic             fail;

  int    vectors     = 0;
  int    miscompares = 0;
  int    cycle       = 0;
  string section     = "reset";

  // Reference model: phase number, cycles spent in it, and the lock samples in flight.
  int m_phase;
  int m_age;
  int m_retries;
  int m_relock;
  bit m_lost;
  bit sync_pipe[$];

  int exp_relock[4] = '{1, 2, 3, 3};

  always #5 clk_in0 = ~clk_in0;

  mmcm0_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES),
    .CNT_W        (CNT_W),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .clk_in0    (clk_in0),
    .reset_n    (reset_n),
    .soft_rst   (soft_rst),
    .mmcm_locked(mmcm_locked),
    .clr_status (clr_status),
    .mmcm_reset (mmcm_reset),
    .sys_rst_n  (sys_rst_n),
    .lock_lost  (lock_lost),
    .relock_cnt (relock_cnt),
    .state      (state),
    .fail       (fail)
  );

  function automatic void modelReset();
    m_phase   = 0;
    m_age     = 0;
    m_retries = 0;
    m_relock  = 0;
    m_lost    = 1'b0;
    sync_pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) sync_pipe.push_back(1'b0);
  endfunction

  function automatic void enterPhase(input int p);
    m_phase = p;
    m_age   = 0;
  endfunction

  // One clock edge of the supervisor as described behaviourally.
  function automatic void modelStep(input bit lk, input bit sr, input bit cs);
    bit ls;
    ls = sync_pipe.pop_front();
    sync_pipe.push_back(lk);
    if (m_phase == 3 && !ls && !sr) begin
      m_lost   = 1'b1;
      m_relock = cs ? 1 : ((m_relock < CNT_MAX) ? m_relock + 1 : CNT_MAX);
    end else if (cs) begin
      m_lost   = 1'b0;
      m_relock = 0;
    end
    m_age++;
    if (sr) begin
      enterPhase(0);
      m_retries = 0;
    end else begin
      case (m_phase)
        0: if (m_age == RST_CYCLES) enterPhase(1);
        1: begin
          if (ls) enterPhase(2);
          else if (m_age == LOCK_TIMEOUT) begin
            m_retries++;
            enterPhase((RETRY_LIMITED && m_retries == MAX_RETRIES) ? 4 : 0);
          end
        end
        2: begin
          if (!ls) enterPhase(1);
          else if (m_age == STABLE_CYCLES) begin
            enterPhase(3);
            m_retries = 0;
          end
        end
        3: if (!ls) enterPhase(0);
        default: ;
      endcase
    end
  endfunction

  function automatic logic [8:0] modelOut();
    logic [2:0] st;
    logic [CNT_W-1:0] rc;
    st = 3'(m_phase);
    rc = CNT_W'(m_relock);
    return {st, (m_phase == 0 || m_phase == 4), (m_phase == 3), m_lost, rc, (m_phase == 4)};
  endfunction

  task automatic checkOutput(input string tag);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {state, mmcm_reset, sys_rst_n, lock_lost, relock_cnt, fail};
    exp = modelOut();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s cycle %0d: observed {state,rst,sys_rst_n,lost,relock,fail}=%b expected %b",
             tag, cycle, obs, exp);
    end
  endtask

  task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s cycle %0d: observed %0d expected %0d", tag, cycle, obs, exp);
    end
  endtask

  // Called at a negedge: drive inputs, step DUT and model on the posedge, check at the next negedge.
  task automatic applyStimulus(input bit lk, input bit sr, input bit cs);
    mmcm_locked = lk;
    soft_rst    = sr;
    clr_status  = cs;
    @(posedge clk_in0);
    modelStep(lk, sr, cs);
    cycle++;
    @(negedge clk_in0);
    checkOutput(section);
  endtask

  task automatic doReset();
    reset_n     = 1'b0;
    soft_rst    = 1'b0;
    clr_status  = 1'b0;
    mmcm_locked = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    checkField("reset_state_const", 8'(state), 8'd0);
    @(negedge clk_in0);
    reset_n = 1'b1;
    cycle   = 0;
  endtask

  initial begin
    bit lvl;
    int len;
    int n;

    reset_n     = 1'b0;
    soft_rst    = 1'b0;
    mmcm_locked = 1'b0;
    clr_status  = 1'b0;
    modelReset();
    @(negedge clk_in0);
    checkOutput("reset");
    checkField("reset_mmcm_reset", 8'(mmcm_reset), 8'd1);
    checkField("reset_sys_rst_n", 8'(sys_rst_n), 8'd0);
    reset_n = 1'b1;

    section = "power_up_lock";
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0);
    checkField("power_up_run_state", 8'(state), 8'd3);
    checkField("power_up_released", 8'(sys_rst_n), 8'd1);

    section = "lock_timeout";
    doReset();
    repeat (53) applyStimulus(1'b0, 1'b0, 1'b0);
    checkField("timeout_pre_edge", 8'(mmcm_reset), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkField("timeout_repulse", 8'(mmcm_reset), 8'd1);
    repeat (64) applyStimulus(1'b0, 1'b0, 1'b0);
    checkField("timeout_held", 8'(sys_rst_n), 8'd0);

    section = "stable_glitch";
    n = 0;
    while (!(m_phase == 2 && m_age == 3) && n < 100) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      n++;
    end
    checkField("glitch_in_stable", 8'(state), 8'd2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkField("glitch_to_wait", 8'(state), 8'd1);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
    checkField("glitch_not_released", 8'(sys_rst_n), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkField("glitch_fresh_release", 8'(sys_rst_n), 8'd1);

    section = "run_lock_loss";
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    checkField("run_before_drops", 8'(state), 8'd3);
    for (int k = 0; k < 4; k++) begin
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (25) applyStimulus(1'b1, 1'b0, 1'b0);
      checkField("relock_count", 8'(relock_cnt), 8'(exp_relock[k]));
      checkField("lock_lost_set", 8'(lock_lost), 8'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkField("clr_lock_lost", 8'(lock_lost), 8'd0);
    checkField("clr_relock", 8'(relock_cnt), 8'd0);

    section = "soft_vs_drop";
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkField("soft_wins_state", 8'(state), 8'd0);
    checkField("soft_wins_lost", 8'(lock_lost), 8'd0);
    checkField("soft_wins_relock", 8'(relock_cnt), 8'd0);
    repeat (25) applyStimulus(1'b1, 1'b0, 1'b0);

    section = "random";
    for (int seg = 0; seg < 80; seg++) begin
      lvl = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        applyStimulus(lvl, ($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0));
      end
    end

    section = "retry_limit";
    doReset();
    repeat (600) applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef MMCM_SUP_RETRY_LIMIT_EN
    checkField("fail_state", 8'(state), 8'd4);
    checkField("fail_flag", 8'(fail), 8'd1);
    checkField("fail_mmcm_reset", 8'(mmcm_reset), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkField("fail_exit_state", 8'(state), 8'd0);
    checkField("fail_exit_flag", 8'(fail), 8'd0);
`else
    checkField("fail_tied_low", 8'(fail), 8'd0);
    checkField("no_fail_state", 8'(state == 3'd4), 8'd0);
`endif
    repeat (30) applyStimulus(1'b1, 1'b0, 1'b0);
    checkField("final_run", 8'(state), 8'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
